// File: rtl/fft_frame_ctrl.sv
// Frame controller around an in-place FFT: loads N samples into set A, starts the core, unloads results.
// Optional FFT_BITREV_EN: unload reads bit-reversed addresses so output comes out in natural order.
module fft_frame_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic                iCLK,
    input  logic                iRESET,
    input  logic [2*DATA_W-1:0] iIN_DATA,
    input  logic                iIN_VALID,
    output logic                oIN_READY,
    output logic                oFFT_START,
    input  logic                iFFT_RDY,
    input  logic                iRES_SET,
    output logic                oOWN,
    output logic                oWR_EN,
    output logic [1:0]          oWR_BANK,
    output logic [ADDR_W-1:0]   oWR_ADDR,
    output logic [2*DATA_W-1:0] oWR_DATA,
    output logic                oRD_EN,
    output logic                oRD_SET,
    output logic [1:0]          oRD_BANK,
    output logic [ADDR_W-1:0]   oRD_ADDR,
    input  logic [2*DATA_W-1:0] iRD_DATA,
    output logic [2*DATA_W-1:0] oOUT_DATA,
    output logic                oOUT_VALID,
    input  logic                iOUT_READY,
    output logic                oOUT_LAST,
    output logic                oBUSY
);

    localparam int IDX_W = ADDR_W + 2;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, UNLOAD} state_t;

    state_t             state_reg;
    logic               in_ready_reg;
    logic               fft_start_reg;
    logic               own_reg;
    logic               busy_reg;
    logic               rd_set_reg;
    logic [IDX_W-1:0]   ld_cnt_reg;
    logic [IDX_W-1:0]   rd_cnt_reg;
    logic [IDX_W-1:0]   out_cnt_reg;
    logic               rd_done_reg;
    logic               rd_pend_reg;
    logic [1:0]         fifo_cnt_reg;
    logic               fifo_wr_ptr_reg;
    logic               fifo_rd_ptr_reg;
    logic [2*DATA_W-1:0] fifo_mem [2];

    logic               accept;
    logic               fifo_valid;
    logic               pop;
    logic               rd_en;
    logic [2:0]         credit;
    logic [IDX_W-1:0]   rd_idx;

`ifdef FFT_BITREV_EN
    generate
        for (genvar gi = 0; gi < IDX_W; gi++) begin : g_bitrev
            assign rd_idx[gi] = rd_cnt_reg[IDX_W-1-gi];
        end
    endgenerate
`else
    assign rd_idx = rd_cnt_reg;
`endif

    assign accept     = in_ready_reg & iIN_VALID;
    assign fifo_valid = (fifo_cnt_reg != 2'd0);
    assign pop        = fifo_valid & iOUT_READY;

    // Reads in flight plus FIFO occupancy stay within 2; a same-cycle pop frees a slot.
    assign credit = {1'b0, fifo_cnt_reg} + {2'b00, rd_pend_reg};
    assign rd_en  = (state_reg == UNLOAD) & ~rd_done_reg & (credit < (3'd2 + {2'b00, pop}));

    assign oIN_READY  = in_ready_reg;
    assign oFFT_START = fft_start_reg;
    assign oOWN       = own_reg;
    assign oBUSY      = busy_reg;
    assign oRD_SET    = rd_set_reg;

    assign oWR_EN   = accept;
    assign oWR_BANK = accept ? ld_cnt_reg[1:0] : 2'b00;
    assign oWR_ADDR = accept ? ld_cnt_reg[IDX_W-1:2] : '0;
    assign oWR_DATA = accept ? iIN_DATA : '0;

    assign oRD_EN   = rd_en;
    assign oRD_BANK = rd_en ? rd_idx[1:0] : 2'b00;
    assign oRD_ADDR = rd_en ? rd_idx[IDX_W-1:2] : '0;

    assign oOUT_VALID = fifo_valid;
    assign oOUT_DATA  = fifo_valid ? fifo_mem[fifo_rd_ptr_reg] : '0;
    assign oOUT_LAST  = fifo_valid & (out_cnt_reg == LAST_IDX);

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            fft_start_reg <= 1'b0;
            own_reg       <= 1'b0;
            busy_reg      <= 1'b0;
            rd_set_reg    <= 1'b0;
            ld_cnt_reg    <= '0;
            rd_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            rd_done_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    state_reg    <= LOAD;
                    in_ready_reg <= 1'b1;
                    own_reg      <= 1'b1;
                    busy_reg     <= 1'b1;
                    ld_cnt_reg   <= '0;
                end
                LOAD: begin
                    if (accept) begin
                        ld_cnt_reg <= ld_cnt_reg + 1'b1;
                        if (ld_cnt_reg == LAST_IDX) begin
                            state_reg     <= START;
                            in_ready_reg  <= 1'b0;
                            own_reg       <= 1'b0;
                            fft_start_reg <= 1'b1;
                        end
                    end
                end
                START: begin
                    fft_start_reg <= 1'b0;
                    state_reg     <= RUN;
                end
                RUN: begin
                    if (iFFT_RDY) begin
                        rd_set_reg  <= iRES_SET;
                        state_reg   <= UNLOAD;
                        own_reg     <= 1'b1;
                        rd_cnt_reg  <= '0;
                        rd_done_reg <= 1'b0;
                        out_cnt_reg <= '0;
                    end
                end
                UNLOAD: begin
                    if (rd_en) begin
                        rd_cnt_reg <= rd_cnt_reg + 1'b1;
                        if (rd_cnt_reg == LAST_IDX)
                            rd_done_reg <= 1'b1;
                    end
                    if (pop) begin
                        out_cnt_reg <= out_cnt_reg + 1'b1;
                        if (out_cnt_reg == LAST_IDX) begin
                            state_reg    <= LOAD;
                            in_ready_reg <= 1'b1;
                            ld_cnt_reg   <= '0;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Read data arrives one cycle after the strobe and is pushed unconditionally.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            rd_pend_reg     <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
        end else begin
            rd_pend_reg <= rd_en;
            if (rd_pend_reg)
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            if (pop)
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            case ({rd_pend_reg, pop})
                2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
                2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
                default: fifo_cnt_reg <= fifo_cnt_reg;
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (rd_pend_reg)
            fifo_mem[fifo_wr_ptr_reg] <= iRD_DATA;
    end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: directed frames with expected writes/reads/outputs queued
// by the stimulus and checked by a negedge monitor.
module tb_fft_frame_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int N      = 2048;

    logic        iCLK = 1'b0;
    logic        iRESET;
    logic [31:0] iIN_DATA;
    logic        iIN_VALID;
    logic        oIN_READY;
    logic        oFFT_START;
    logic        iFFT_RDY;
    logic        iRES_SET;
    logic        oOWN;
    logic        oWR_EN;
    logic [1:0]  oWR_BANK;
    logic [8:0]  oWR_ADDR;
    logic [31:0] oWR_DATA;
    logic        oRD_EN;
    logic        oRD_SET;
    logic [1:0]  oRD_BANK;
    logic [8:0]  oRD_ADDR;
    logic [31:0] iRD_DATA;
    logic [31:0] oOUT_DATA;
    logic        oOUT_VALID;
    logic        iOUT_READY;
    logic        oOUT_LAST;
    logic        oBUSY;

    fft_frame_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .iCLK(iCLK), .iRESET(iRESET),
        .iIN_DATA(iIN_DATA), .iIN_VALID(iIN_VALID), .oIN_READY(oIN_READY),
        .oFFT_START(oFFT_START), .iFFT_RDY(iFFT_RDY), .iRES_SET(iRES_SET),
        .oOWN(oOWN),
        .oWR_EN(oWR_EN), .oWR_BANK(oWR_BANK), .oWR_ADDR(oWR_ADDR), .oWR_DATA(oWR_DATA),
        .oRD_EN(oRD_EN), .oRD_SET(oRD_SET), .oRD_BANK(oRD_BANK), .oRD_ADDR(oRD_ADDR),
        .iRD_DATA(iRD_DATA),
        .oOUT_DATA(oOUT_DATA), .oOUT_VALID(oOUT_VALID), .iOUT_READY(iOUT_READY),
        .oOUT_LAST(oOUT_LAST), .oBUSY(oBUSY)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int out_seen = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    int rd_seen = 0;
    bit dir_rd = 0;

    logic [42:0] exp_wr_q[$];
    logic [11:0] exp_rd_q[$];
    logic [31:0] exp_out_q[$];

    logic [31:0] mem_a [N];
    logic [31:0] mem_b [N];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sample_val(input int seed, input int k);
        logic [15:0] hi, lo;
        hi = 16'((seed * 4369 + k * 3) & 16'hFFFF);
        lo = 16'((k ^ 16'hF00F ^ seed) & 16'hFFFF);
        return {hi, lo};
    endfunction

    function automatic logic [31:0] res_val(input int i);
        logic [15:0] hi, lo;
        hi = 16'((16'hB000 + i) & 16'hFFFF);
        lo = 16'((i * 5 + 7) & 16'hFFFF);
        return {hi, lo};
    endfunction

    function automatic int read_index(input int j);
        int r;
`ifdef FFT_BITREV_EN
        r = 0;
        for (int b = 0; b < 11; b++)
            if (j[b]) r = r | (1 << (10 - b));
`else
        r = j;
`endif
        return r;
    endfunction

    // Hand-computed {bank, addr} for unload reads j = 1..3.
    function automatic logic [10:0] dir_loc(input int j);
        logic [10:0] v;
`ifdef FFT_BITREV_EN
        case (j)
            1: v = {2'd0, 9'd256};
            2: v = {2'd0, 9'd128};
            default: v = {2'd0, 9'd384};
        endcase
`else
        case (j)
            1: v = {2'd1, 9'd0};
            2: v = {2'd2, 9'd0};
            default: v = {2'd3, 9'd0};
        endcase
`endif
        return v;
    endfunction

    // Bank memory model: writes go to set A, reads return one cycle later.
    always @(posedge iCLK) begin
        cyc <= cyc + 1;
        if (oWR_EN) mem_a[{oWR_ADDR, oWR_BANK}] <= oWR_DATA;
        if (oRD_EN) iRD_DATA <= oRD_SET ? mem_b[{oRD_ADDR, oRD_BANK}] : mem_a[{oRD_ADDR, oRD_BANK}];
    end

    always @(negedge iCLK) begin
        if (iRESET) begin
            check("strobe_rules", {oWR_EN & oRD_EN, ~oOWN & (oWR_EN | oRD_EN)}, 0);
            if (oWR_EN) begin
                if (exp_wr_q.size() == 0) check("unexpected_write", {oWR_BANK, oWR_ADDR, oWR_DATA}, 0);
                else check("write", {oWR_BANK, oWR_ADDR, oWR_DATA}, exp_wr_q.pop_front());
            end
            if (oRD_EN) begin
                if (exp_rd_q.size() == 0) check("unexpected_read", {oRD_SET, oRD_BANK, oRD_ADDR}, 0);
                else check("read", {oRD_SET, oRD_BANK, oRD_ADDR}, exp_rd_q.pop_front());
                if (dir_rd && rd_seen >= 1 && rd_seen <= 3)
                    check($sformatf("read_loc_j%0d", rd_seen), {oRD_BANK, oRD_ADDR}, dir_loc(rd_seen));
                rd_seen++;
            end
            if (oOUT_VALID && iOUT_READY) begin
                if (exp_out_q.size() == 0) check("unexpected_output", oOUT_DATA, 0);
                else check("out_data", oOUT_DATA, exp_out_q.pop_front());
                check("out_last", oOUT_LAST, (out_seen == N - 1));
                if (out_seen == 0) first_cyc = cyc;
                last_cyc = cyc;
                out_seen++;
            end
        end
    end

    function automatic logic [94:0] all_outs();
        return {oIN_READY, oFFT_START, oOWN, oWR_EN, oWR_BANK, oWR_ADDR, oWR_DATA,
                oRD_EN, oRD_SET, oRD_BANK, oRD_ADDR, oOUT_DATA, oOUT_VALID, oOUT_LAST, oBUSY};
    endfunction

    task automatic load_frame(input int seed, input int nsamp, input bit chk_first);
        bit acc;
        for (int k = 0; k < nsamp; k++) begin
            iIN_VALID = 1'b1;
            iIN_DATA  = sample_val(seed, k);
            iFFT_RDY  = (k == 10);
            exp_wr_q.push_back({2'(k & 3), 9'(k >> 2), sample_val(seed, k)});
            acc = 1'b0;
            for (int t = 0; t < 8 && !acc; t++) begin
                @(negedge iCLK);
                acc = oIN_READY;
                if (chk_first && k == 0 && acc)
                    check("first_wr_loc", {oWR_EN, oWR_BANK, oWR_ADDR}, {1'b1, 11'd0});
                @(posedge iCLK); #1;
                iFFT_RDY = 1'b0;
            end
            check("load_accept", acc, 1'b1);
        end
        iIN_VALID = 1'b0;
    endtask

    task automatic unload_frame(input int seed, input bit set, input bit stall, input int run_cycles);
        int n;
        int ph;
        int r;
        @(negedge iCLK);
        check("start_pulse", {oFFT_START, oIN_READY, oOWN, oBUSY}, 4'b1001);
        @(negedge iCLK);
        check("start_len", {oFFT_START, oOWN, oBUSY}, 3'b001);
        repeat (run_cycles) @(posedge iCLK);
        #1;
        for (int j = 0; j < N; j++) begin
            r = read_index(j);
            exp_rd_q.push_back({set, 2'(r & 3), 9'(r >> 2)});
            exp_out_q.push_back(set ? res_val(r) : sample_val(seed, r));
        end
        out_seen   = 0;
        rd_seen    = 0;
        dir_rd     = set;
        iOUT_READY = 1'b1;
        iRES_SET   = set;
        iFFT_RDY   = 1'b1;
        @(posedge iCLK); #1;
        iFFT_RDY = 1'b0;
        iRES_SET = ~set;
        for (n = 0; n < 5; n++) begin
            @(negedge iCLK);
            if (n == 0) check("rd_set_latch", oRD_SET, set);
            if (oOUT_VALID) break;
        end
        check("first_valid_lat", (n <= 2), 1'b1);
        ph = 0;
        for (int c = 0; c < 20000 && out_seen < N; c++) begin
            @(posedge iCLK); #1;
            if (stall) iOUT_READY = (ph < 4) ? ~ph[0] : ($urandom_range(0, 2) != 0);
            ph++;
        end
        check("out_count", out_seen, N);
        if (!stall) check("throughput", last_cyc - first_cyc, N - 1);
        iOUT_READY = 1'b0;
        @(negedge iCLK);
        check("back_to_load", {oIN_READY, oOWN, oOUT_VALID}, 3'b110);
    endtask

    initial begin
        for (int i = 0; i < N; i++) mem_b[i] = res_val(i);
        iRESET     = 1'b1;
        iIN_DATA   = 32'hDEAD_BEEF;
        iIN_VALID  = 1'b0;
        iFFT_RDY   = 1'b0;
        iRES_SET   = 1'b0;
        iOUT_READY = 1'b0;
        #2 iRESET = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        check("reset_outputs", all_outs(), 0);
        @(posedge iCLK); #1;
        iRESET = 1'b1;
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        check("ready_after_reset", {oIN_READY, oBUSY, oOWN}, 3'b111);
        @(posedge iCLK); #1;

        // Frame 1: results from set B, continuous output.
        load_frame(1, N, 1'b0);
        unload_frame(1, 1'b1, 1'b0, 998);

        // Frame 2: results read back from set A (the loaded samples), with output stalls.
        @(posedge iCLK); #1;
        load_frame(2, N, 1'b1);
        unload_frame(2, 1'b0, 1'b1, 20);

        // Frame 3: reset in the middle of a load, then restart.
        @(posedge iCLK); #1;
        load_frame(3, 101, 1'b0);
        iIN_VALID = 1'b1;
        iIN_DATA  = 32'hCAFE_F00D;
        iRESET    = 1'b0;
        exp_wr_q.delete();
        exp_rd_q.delete();
        exp_out_q.delete();
        #1;
        check("midload_reset_outputs", all_outs(), 0);
        repeat (3) @(posedge iCLK);
        #1;
        iIN_VALID = 1'b0;
        iRESET    = 1'b1;
        @(posedge iCLK);
        @(posedge iCLK);
        @(negedge iCLK);
        check("ready_after_reset2", {oIN_READY, oBUSY}, 2'b11);
        @(posedge iCLK); #1;
        load_frame(4, 4, 1'b1);
        @(negedge iCLK);

        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        check("out_queue_drained", exp_out_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
